// File: rtl/mux_2to1.sv
// -----------------------------------------------------------------------------
// mux_2to1
//
// Two-input data multiplexer. Select steers A_in (Select=0) or B_in (Select=1)
// onto Y, bitwise across all WIDTH bits. The unselected input never reaches Y.
//
// Parameters
//   WIDTH    data width of A_in, B_in and Y, in bits (>= 1)
//   OUT_REG  0: Y is purely combinational, clk and rst are ignored
//            1: Y is registered on the rising edge of clk (1-cycle latency);
//               rst clears the register asynchronously to all-zeros
//
// Ports
//   clk     in   1      system clock, rising edge (used only when OUT_REG=1)
//   rst     in   1      asynchronous active-high reset (only when OUT_REG=1)
//   Select  in   1      source select: 0 -> A_in, 1 -> B_in
//   A_in    in   WIDTH  data input routed when Select=0
//   B_in    in   WIDTH  data input routed when Select=1
//   Y       out  WIDTH  selected data
// -----------------------------------------------------------------------------
module mux_2to1 #(
    parameter int WIDTH   = 1,
    parameter bit OUT_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Select,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] Y
);

    // Selected source. Select and both data words feed one expression, so in
    // the registered build all three are captured by the same clock edge and
    // an old Select can never pair with new data.
    logic [WIDTH-1:0] mux_out;

    // NOTE: every output of an always_comb is assigned on every path through
    // the block; a path that leaves it unassigned infers a latch.
    always_comb begin
        mux_out = Select ? B_in : A_in;
    end

    generate
        if (OUT_REG) begin : g_reg
            logic [WIDTH-1:0] y_q;

            // NOTE: clocked state is updated with non-blocking assignments so
            // every register samples pre-edge values regardless of block order.
            // Reset is in the sensitivity list: Y clears as soon as rst rises,
            // without waiting for clk, and any value captured before the reset
            // is thrown away.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    y_q <= '0;
                end else begin
                    y_q <= mux_out;
                end
            end

            assign Y = y_q;
        end else begin : g_comb
            // Zero-latency path; clk and rst have no function in this build.
            assign Y = mux_out;

            // Consumes the clock and reset so the combinational build has no
            // dangling inputs.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
        end
    endgenerate

endmodule

// File: tb/tb_mux_2to1.sv
// -----------------------------------------------------------------------------
// tb_mux_2to1
//
// Exercises four builds of mux_2to1 side by side: combinational WIDTH=1 and
// WIDTH=8, registered WIDTH=1 and WIDTH=8. Expected values come from a
// reference that treats selection as arithmetic weighting of the two sources,
// y = a*(1-sel) + b*sel, plus fixed truth-table constants.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mux_2to1;

    int checks   = 0;
    int failures = 0;

    logic clk;
    logic comb_rst;

    // Combinational, WIDTH=1
    logic       c1_sel, c1_a, c1_b;
    logic       c1_y;
    // Combinational, WIDTH=8
    logic       c8_sel;
    logic [7:0] c8_a, c8_b;
    logic [7:0] c8_y;
    // Registered, WIDTH=1
    logic       r1_rst, r1_sel, r1_a, r1_b;
    logic       r1_y;
    // Registered, WIDTH=8
    logic       r8_rst, r8_sel;
    logic [7:0] r8_a, r8_b;
    logic [7:0] r8_y;

    mux_2to1 #(.WIDTH(1), .OUT_REG(1'b0)) u_comb1 (
        .clk(clk), .rst(comb_rst), .Select(c1_sel), .A_in(c1_a), .B_in(c1_b), .Y(c1_y)
    );
    mux_2to1 #(.WIDTH(8), .OUT_REG(1'b0)) u_comb8 (
        .clk(clk), .rst(comb_rst), .Select(c8_sel), .A_in(c8_a), .B_in(c8_b), .Y(c8_y)
    );
    mux_2to1 #(.WIDTH(1), .OUT_REG(1'b1)) u_reg1 (
        .clk(clk), .rst(r1_rst), .Select(r1_sel), .A_in(r1_a), .B_in(r1_b), .Y(r1_y)
    );
    mux_2to1 #(.WIDTH(8), .OUT_REG(1'b1)) u_reg8 (
        .clk(clk), .rst(r8_rst), .Select(r8_sel), .A_in(r8_a), .B_in(r8_b), .Y(r8_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: selection as arithmetic weighting of the two sources.
    function automatic int ref_sel(input int sel, input int a, input int b);
        return a * (1 - sel) + b * sel;
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        r1_rst = 1'b1; r1_sel = 1'b1; r1_a = 1'b0; r1_b = 1'b1;
        r8_rst = 1'b1; r8_sel = 1'b0; r8_a = 8'hFF; r8_b = 8'h00;
        #1;
        checks++;
        if (r1_y !== 1'b0) begin
            failures++; $display("FAIL reset_r1_initial: got %b expected 0", r1_y);
        end
        checks++;
        if (r8_y !== 8'h00) begin
            failures++; $display("FAIL reset_r8_initial: got %h expected 00", r8_y);
        end
        // Held through a clock edge while rst stays high.
        @(posedge clk); #1;
        checks++;
        if (r1_y !== 1'b0 || r8_y !== 8'h00) begin
            failures++; $display("FAIL reset_hold: got r1=%b r8=%h expected 0/00", r1_y, r8_y);
        end
        // Deassert mid-cycle: nothing changes until the next rising edge.
        @(negedge clk); r1_rst = 1'b0; r8_rst = 1'b0; #1;
        checks++;
        if (r1_y !== 1'b0 || r8_y !== 8'h00) begin
            failures++; $display("FAIL reset_release_no_edge: got r1=%b r8=%h expected 0/00", r1_y, r8_y);
        end
        @(posedge clk); #1;
        checks++;
        if (r1_y !== 1'b1 || r8_y !== 8'hFF) begin
            failures++; $display("FAIL reset_first_load: got r1=%b r8=%h expected 1/ff", r1_y, r8_y);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_truth_table();
        logic [7:0] exp_tab;
        logic [2:0] v;
        int bad_pass;
        exp_tab = 8'b1010_1100; // bit k = Y for {Select,A_in,B_in}=k: 0,0,1,1,0,1,0,1
        for (int pass = 0; pass < 12; pass++) begin
            bad_pass = 0;
            for (int k = 0; k < 8; k++) begin
                v = 3'(k);
                c1_sel = v[2]; c1_a = v[1]; c1_b = v[0];
                #1;
                checks++;
                if (c1_y !== exp_tab[k]) begin
                    failures++; bad_pass = 1;
                    $display("FAIL truth_table pass=%0d step=%0d: got %b expected %b", pass, k, c1_y, exp_tab[k]);
                end
                checks++;
                if (int'(c1_y) !== ref_sel(int'(v[2]), int'(v[1]), int'(v[0]))) begin
                    failures++;
                    $display("FAIL truth_table_model pass=%0d step=%0d: got %b expected %0d", pass, k, c1_y,
                             ref_sel(int'(v[2]), int'(v[1]), int'(v[0])));
                end
                #4;
            end
            if (bad_pass != 0) $display("note: truth-table pass %0d had errors", pass);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_isolation();
        c8_sel = 1'b0; c8_a = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            c8_b = (i % 2 == 0) ? 8'h00 : 8'hFF;
            #1;
            checks++;
            if (c8_y !== 8'hA5) begin
                failures++; $display("FAIL isolation_sel0 b=%h: got %h expected a5", c8_b, c8_y);
            end
            #4;
        end
        c8_sel = 1'b1; c8_b = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            c8_a = (i % 2 == 0) ? 8'h00 : 8'hFF;
            #1;
            checks++;
            if (c8_y !== 8'h3C) begin
                failures++; $display("FAIL isolation_sel1 a=%h: got %h expected 3c", c8_a, c8_y);
            end
            #4;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_comb_ignores_rst();
        c8_sel = 1'b1; c8_a = 8'h11; c8_b = 8'h5A; comb_rst = 1'b1;
        #1;
        checks++;
        if (c8_y !== 8'h5A) begin
            failures++; $display("FAIL comb_ignores_rst: got %h expected 5a", c8_y);
        end
        comb_rst = 1'b0;
        #4;
    endtask

    // ------------------------------------------------------------------
    task automatic test_latency();
        @(negedge clk); r1_sel = 1'b0; r1_a = 1'b0; r1_b = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (r1_y !== 1'b0) begin
            failures++; $display("FAIL latency_setup: got %b expected 0", r1_y);
        end
        @(negedge clk); r1_sel = 1'b1; r1_b = 1'b1; #1;
        checks++;
        if (r1_y !== 1'b0) begin
            failures++; $display("FAIL latency_mid_cycle: got %b expected 0", r1_y);
        end
        #3; // just before the rising edge
        checks++;
        if (r1_y !== 1'b0) begin
            failures++; $display("FAIL latency_pre_edge: got %b expected 0", r1_y);
        end
        @(posedge clk); #1;
        checks++;
        if (r1_y !== 1'b1) begin
            failures++; $display("FAIL latency_one_cycle: got %b expected 1", r1_y);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        // Y is 1 from the latency test; inputs still select B_in=1.
        @(negedge clk); #2;
        r1_rst = 1'b1; #1;
        checks++;
        if (r1_y !== 1'b0) begin
            failures++; $display("FAIL async_reset_immediate: got %b expected 0", r1_y);
        end
        @(posedge clk); #1;
        checks++;
        if (r1_y !== 1'b0) begin
            failures++; $display("FAIL async_reset_hold: got %b expected 0", r1_y);
        end
        @(negedge clk); r1_rst = 1'b0; #1;
        checks++;
        if (r1_y !== 1'b0) begin
            failures++; $display("FAIL async_reset_release: got %b expected 0", r1_y);
        end
        @(posedge clk); #1;
        checks++;
        if (r1_y !== 1'b1) begin
            failures++; $display("FAIL async_reset_reload: got %b expected 1", r1_y);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_select_flip();
        logic exp_seq [3];
        exp_seq = '{1'b0, 1'b1, 1'b0};
        c1_a = 1'b0; c1_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c1_sel = exp_seq[i]; // Select path 0 -> 1 -> 0, Y must track it
            #1;
            checks++;
            if (c1_y !== exp_seq[i]) begin
                failures++; $display("FAIL select_flip_comb step=%0d: got %b expected %b", i, c1_y, exp_seq[i]);
            end
            #4;
        end
        r1_a = 1'b0; r1_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); r1_sel = exp_seq[i];
            @(posedge clk); #1;
            checks++;
            if (r1_y !== exp_seq[i]) begin
                failures++; $display("FAIL select_flip_reg step=%0d: got %b expected %b", i, r1_y, exp_seq[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random_comb();
        int e;
        for (int i = 0; i < 200; i++) begin
            c8_sel = 1'($urandom_range(0, 1));
            c8_a   = 8'($urandom);
            c8_b   = 8'($urandom);
            #1;
            e = ref_sel(int'(c8_sel), int'(c8_a), int'(c8_b));
            checks++;
            if (int'(c8_y) !== e) begin
                failures++; $display("FAIL random_comb i=%0d: got %h expected %h", i, c8_y, e);
            end
            #2;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random_reg();
        int exp_y;
        int e;
        exp_y = int'(r8_y); // settled state carried in from earlier phases
        r8_rst = 1'b0;
        @(negedge clk);
        exp_y = int'(r8_y);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            r8_sel = 1'($urandom_range(0, 1));
            r8_a   = 8'($urandom);
            r8_b   = 8'($urandom);
            r8_rst = ($urandom_range(0, 15) == 0);
            #1;
            // Between edges Y either holds or, under reset, is already zero.
            e = r8_rst ? 0 : exp_y;
            checks++;
            if (int'(r8_y) !== e) begin
                failures++; $display("FAIL random_reg_between i=%0d: got %h expected %h", i, r8_y, e);
            end
            @(posedge clk);
            exp_y = r8_rst ? 0 : ref_sel(int'(r8_sel), int'(r8_a), int'(r8_b));
            #1;
            checks++;
            if (int'(r8_y) !== exp_y) begin
                failures++; $display("FAIL random_reg_edge i=%0d: got %h expected %h", i, r8_y, exp_y);
            end
        end
        @(negedge clk); r8_rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    initial begin
        comb_rst = 1'b0;
        c1_sel = 1'b0; c1_a = 1'b0; c1_b = 1'b0;
        c8_sel = 1'b0; c8_a = 8'h00; c8_b = 8'h00;
        test_reset();
        test_truth_table();
        test_isolation();
        test_comb_ignores_rst();
        test_latency();
        test_async_reset();
        test_select_flip();
        test_random_comb();
        test_random_reg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-time bound: the sequence above needs well under 20 us.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
